lcr_port_uart: RTL and testbench
================================

Name: lcr_port_uart

Overview:
- Port-mapped 8N1 UART that acts as the responder on the LCR580 I/O port bus.
- It decodes the CPU's OUT (port_we) and IN (port_rd) strobes and returns read data on port_in.
- It buffers traffic in TX and RX FIFOs and raises a level interrupt request.
- It sits beside the CPU. Its port_in feeds the CPU's port_in; address[7:0], out, port_we and port_rd come from the CPU.

Parameters:
- BASE, 8'h10, first port number; the block occupies BASE..BASE+2.
- CLKS_PER_BIT, 217, clock cycles per serial bit (25 MHz / 115200). Must be >= 4.
- FIFO_DEPTH, 4, entries per FIFO. Power of two, >= 2.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- ce  in  1  CPU clock enable; bus strobes are qualified by it
- address  in  8  port number (CPU address[7:0])
- data_in  in  8  write data (CPU out)
- port_we  in  1  OUT strobe
- port_rd  in  1  IN strobe
- port_in  out  8  read data to CPU
- rxd  in  1  serial input, asynchronous
- txd  out  1  serial output
- irq  out  1  level interrupt request

Behaviour:
- Bus qualification:
  - A write occurs only on a clock where ce && port_we && address in range.
  - A read side-effect occurs only on a clock where ce && port_rd && address in range.
  - Strobes may stay high for several clocks while ce=0. Each strobe acts exactly once.
- port_in is combinational from address and state, valid in the same cycle as port_rd; the CPU samples it at the ce edge.
  - Out-of-range address reads 8'hFF.
- Register map:
  - BASE+0 DATA
    - W: push data_in into the TX FIFO. If the FIFO is full, the byte is dropped and tx_ovf is set.
    - R: head of the RX FIFO; the qualified read pops it. Reading while empty returns 8'h00 with no pop.
  - BASE+1 STATUS (read-only; writes are ignored)
    - bit0 rx_avail
    - bit1 tx_not_full
    - bit2 tx_idle (FIFO empty and shifter idle)
    - bit3 rx_ovr
    - bit4 frame_err
    - bit5 tx_ovf
    - bits 7:6 read 0
  - BASE+2 CTRL
    - R/W bit0 rx_ie, bit1 tx_ie.
    - Writing bit7=1 clears rx_ovr, frame_err and tx_ovf; bit7 itself is not stored and reads 0.
- irq = (rx_ie && rx_avail) || (tx_ie && tx_idle). It is registered (one clock after the causing state).
- TX FSM states: IDLE -> START -> DATA(8 bits) -> STOP -> IDLE.
  - IDLE with FIFO non-empty pops one byte and enters START on the next clock.
  - Each bit lasts exactly CLKS_PER_BIT clocks. Data is sent LSB first; the stop bit is 1.
  - A back-to-back byte begins START the clock after STOP ends, with no idle gap.
  - txd = 1 in IDLE.
- RX path:
  - rxd passes through a 2-flop synchroniser, initialised to 1 on reset.
  - States: IDLE -> START -> DATA -> STOP.
  - IDLE: a falling edge (sync 1->0) starts the counter.
  - START: the line is sampled at CLKS_PER_BIT/2. If it is high, the edge was a glitch: return to IDLE and push nothing.
  - DATA: each data bit is sampled CLKS_PER_BIT after the previous sample.
  - STOP: the stop bit is sampled at the same spacing.
    - Stop = 1: push the byte. If the RX FIFO is full, drop the byte and set rx_ovr.
    - Stop = 0: set frame_err, discard the byte, and wait for the line to return to 1 before re-arming IDLE.
- Baud counters run every clock, independent of ce; a stalled CPU does not affect the line timing.
- Simultaneous events:
  - RX push and CPU pop on the same clock both take effect; occupancy is unchanged.
  - TX FSM pop and CPU push on the same clock both take effect, including when the FIFO is full (the push then succeeds).
  - A CTRL clear and a new error on the same clock: the error wins (the bit stays set).
- Reset values, applied on the next clock edge even mid-frame:
  - txd=1, irq=0
  - all FIFOs empty, all flags 0, CTRL=0
  - both FSMs IDLE, counters 0
- FIFO pointers are log2(FIFO_DEPTH) bits plus a wrap bit and wrap naturally. Occupancy is exact at 0 and FIFO_DEPTH.

Decomposition:
- Package lcr_port_pkg holds:
  - register offsets OFS_DATA=0, OFS_STATUS=1, OFS_CTRL=2
  - STATUS bit indices
  - CTRL bit indices
  - TX/RX state enum (IDLE, START, DATA, STOP)
- Sub-module lcr_uart_fifo: synchronous FIFO (width 8, depth param) with push, pop, full, empty and head data, using a show-ahead read. It is instantiated twice.

Test Plan (CLKS_PER_BIT=8, FIFO_DEPTH=4, BASE=8'h10; ce=1 unless stated):
- OUT 8'h10 <- 8'hA5 -> txd: start 0, then 1,0,1,0,0,1,0,1, then stop 1, each held 8 clocks. STATUS bit2 reads 0 during the frame and 1 after it.
- Drive 0x3C 8N1 on rxd -> STATUS=8'h07. IN 8'h10 returns 8'h3C; afterwards STATUS=8'h06 and a further IN 8'h10 returns 8'h00.
- Receive 5 bytes without reading -> bytes 1-4 are read back in order, byte 5 is lost and STATUS bit3=1. OUT 8'h12 <- 8'h80 clears it.
- Hold port_rd=1 with address 8'h10 for 4 clocks while ce pulses once -> exactly one RX pop. IN 8'h55 returns 8'hFF.
- Drive a frame with stop bit 0 -> frame_err=1, no push. A 2-clock low glitch on rxd -> no push and no error.
- CTRL=8'h01, then receive a byte -> irq=1 one clock after rx_avail. Reset mid-TX-frame -> txd=1, STATUS=8'h06 and irq=0 after the edge.

Source files
------------

// File: rtl/lcr_port_pkg.sv
// lcr_port_pkg: register offsets, STATUS/CTRL bit indices and the shared TX/RX state type
package lcr_port_pkg;
    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;
    localparam logic [1:0] OFS_CTRL   = 2'd2;

    localparam int ST_RX_AVAIL    = 0;
    localparam int ST_TX_NOT_FULL = 1;
    localparam int ST_TX_IDLE     = 2;
    localparam int ST_RX_OVR      = 3;
    localparam int ST_FRAME_ERR   = 4;
    localparam int ST_TX_OVF      = 5;

    localparam int CT_RX_IE = 0;
    localparam int CT_TX_IE = 1;
    localparam int CT_CLR   = 7;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/lcr_uart_fifo.sv
// lcr_uart_fifo: 8-bit show-ahead synchronous FIFO
// Ports: clock, reset_n (sync, active-low); push/din write side; pop/head read side
// (head is the oldest entry, valid whenever empty=0); full, empty status.
module lcr_uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        do_push, do_pop;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign do_pop  = pop && !empty;
    // a pop on the same clock frees the slot, so a push into a full FIFO still lands
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clock)
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/lcr_port_uart.sv
// lcr_port_uart: port-mapped 8N1 UART responder on the LCR580 I/O port bus
// Ports: clock, reset_n (sync, active-low); ce qualifies the CPU strobes port_we/port_rd
// at address with write data data_in; port_in is combinational read data; rxd/txd serial
// line; irq registered level interrupt request.
module lcr_port_uart
    import lcr_port_pkg::*;
#(
    parameter logic [7:0] BASE         = 8'h10,
    parameter int         CLKS_PER_BIT = 217,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ce,
    input  logic [7:0] address,
    input  logic [7:0] data_in,
    input  logic       port_we,
    input  logic       port_rd,
    output logic [7:0] port_in,
    input  logic       rxd,
    output logic       txd,
    output logic       irq
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

    logic [7:0] off, status, tx_head, rx_head, tx_sh, rx_sh;
    logic [1:0] sel, ctrl;
    logic       hit, wr_q, rd_q, clr;
    logic       tx_push, tx_pop, tx_full, tx_empty, tx_idle, tx_end;
    logic       rx_push, rx_pop, rx_full, rx_empty, rx_done;
    logic       rx_s1, rx_s2, rx_last, rx_ovr, frame_err, tx_ovf;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [2:0]    tx_bit, rx_bit;
    uart_state_t   tx_state, rx_state;

    // offset arithmetic wraps, so the 3-port window works for any BASE
    assign off  = address - BASE;
    assign hit  = off < 8'd3;
    assign sel  = off[1:0];
    assign wr_q = ce && port_we && hit;
    assign rd_q = ce && port_rd && hit;
    assign clr  = wr_q && sel == OFS_CTRL && data_in[CT_CLR];

    lcr_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock(clock), .reset_n(reset_n), .push(tx_push), .pop(tx_pop),
        .din(data_in), .head(tx_head), .full(tx_full), .empty(tx_empty)
    );
    lcr_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock(clock), .reset_n(reset_n), .push(rx_push), .pop(rx_pop),
        .din(rx_sh), .head(rx_head), .full(rx_full), .empty(rx_empty)
    );

    assign tx_push = wr_q && sel == OFS_DATA;
    assign tx_end  = tx_cnt == LAST;
    // the shifter loads from IDLE, or straight out of a finished stop bit for back-to-back bytes
    assign tx_pop  = !tx_empty && (tx_state == IDLE || (tx_state == STOP && tx_end));
    assign tx_idle = tx_empty && tx_state == IDLE;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            txd      <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= START;
            tx_cnt   <= '0;
            tx_sh    <= tx_head;
            txd      <= 1'b0;
        end else if (tx_state != IDLE) begin
            tx_cnt <= tx_end ? '0 : tx_cnt + 1'b1;
            if (tx_end) begin
                case (tx_state)
                    START: begin
                        tx_state <= DATA;
                        tx_bit   <= '0;
                        txd      <= tx_sh[0];
                        tx_sh    <= tx_sh >> 1;
                    end
                    DATA: begin
                        if (tx_bit == 3'd7) begin
                            tx_state <= STOP;
                            txd      <= 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                            txd    <= tx_sh[0];
                            tx_sh  <= tx_sh >> 1;
                        end
                    end
                    default: begin
                        tx_state <= IDLE;
                        txd      <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign rx_done = rx_state == STOP && rx_cnt == LAST;
    assign rx_push = rx_done && rx_s2;
    assign rx_pop  = rd_q && sel == OFS_DATA;

    // after a framing error IDLE needs a fresh 1->0 edge, which only appears once the line has gone high again
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_last  <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_last <= rx_s2;
            rx_cnt  <= rx_cnt + 1'b1;
            case (rx_state)
                IDLE: begin
                    rx_cnt <= '0;
                    if (rx_last && !rx_s2) rx_state <= START;
                end
                START: if (rx_cnt == HALF) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? IDLE : DATA;
                end
                DATA: if (rx_cnt == LAST) begin
                    rx_cnt <= '0;
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state <= STOP;
                end
                default: if (rx_done) begin
                    rx_cnt   <= '0;
                    rx_state <= IDLE;
                end
            endcase
        end
    end

    // a new error on the same clock as a clear keeps the flag set
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
            tx_ovf    <= 1'b0;
            ctrl      <= '0;
            irq       <= 1'b0;
        end else begin
            rx_ovr    <= (rx_push && rx_full && !rx_pop) || (rx_ovr && !clr);
            frame_err <= (rx_done && !rx_s2) || (frame_err && !clr);
            tx_ovf    <= (tx_push && tx_full && !tx_pop) || (tx_ovf && !clr);
            if (wr_q && sel == OFS_CTRL) ctrl <= data_in[CT_TX_IE:CT_RX_IE];
            irq <= (ctrl[CT_RX_IE] && !rx_empty) || (ctrl[CT_TX_IE] && tx_idle);
        end
    end

    always_comb begin
        status                 = '0;
        status[ST_RX_AVAIL]    = !rx_empty;
        status[ST_TX_NOT_FULL] = !tx_full;
        status[ST_TX_IDLE]     = tx_idle;
        status[ST_RX_OVR]      = rx_ovr;
        status[ST_FRAME_ERR]   = frame_err;
        status[ST_TX_OVF]      = tx_ovf;
    end

    assign port_in = !hit               ? 8'hFF :
                     sel == OFS_DATA    ? (rx_empty ? 8'h00 : rx_head) :
                     sel == OFS_STATUS  ? status : {6'b0, ctrl};
endmodule

// File: tb/tb_lcr_port_uart.sv
// tb_lcr_port_uart: scoreboard bench for lcr_port_uart at 8 clocks per bit, depth-4 FIFOs
module tb_lcr_port_uart;
    logic       clock = 0, reset_n = 0, ce = 1, port_we = 0, port_rd = 0, rxd = 1;
    logic [7:0] address = 0, data_in = 0;
    logic [7:0] port_in;
    logic       txd, irq;
    int         n_cmp = 0, n_bad = 0;
    logic [7:0] rxq[$], txq[$];

    lcr_port_uart #(.BASE(8'h10), .CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .ce(ce), .address(address), .data_in(data_in),
        .port_we(port_we), .port_rd(port_rd), .port_in(port_in), .rxd(rxd), .txd(txd), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        address = a; data_in = d; port_we = 1;
        @(negedge clock);
        port_we = 0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        address = a; port_rd = 1;
        #1 d = port_in;
        @(negedge clock);
        port_rd = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic rx_pop_chk(input string tag);
        logic [7:0] d;
        rd(8'h10, d);
        check(tag, d, rxq.pop_front());
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (8) @(negedge clock);
        end
        rxd = 1;
        repeat (4) @(negedge clock);
    endtask

    // samples each bit cell on its first and last clock, so a wrong bit length shows up
    task automatic tx_frame(input bit mid, output int w);
        logic [9:0] first, last, ef;
        logic [7:0] e;
        e = txq.pop_front();
        ef = {1'b1, e, 1'b0};
        w = 0;
        while (txd !== 1'b0 && w < 300) begin
            @(negedge clock);
            w++;
        end
        for (int b = 0; b < 10; b++) begin
            first[b] = txd;
            if (mid && b == 4) begin
                address = 8'h11;
                #1 check("tx_idle_mid", 16'(port_in[2]), 16'd0);
            end
            repeat (7) @(negedge clock);
            last[b] = txd;
            @(negedge clock);
        end
        check("tx_frame_first", 16'(first), 16'(ef));
        check("tx_frame_last", 16'(last), 16'(ef));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int w;
        bit seen;
        repeat (3) @(negedge clock);
        reset_n = 1;
        @(negedge clock);
        check("rst_txd", 16'(txd), 16'd1);
        check("rst_irq", 16'(irq), 16'd0);
        rd_chk("rst_status", 8'h11, 8'h06);
        rd_chk("rst_ctrl", 8'h12, 8'h00);
        rd_chk("rst_data_empty", 8'h10, 8'h00);

        txq.push_back(8'hA5);
        wr(8'h10, 8'hA5);
        tx_frame(1, w);
        rd_chk("tx_idle_after", 8'h11, 8'h06);

        for (int i = 0; i < 5; i++) txq.push_back(8'(8'h30 + i));
        fork
            begin
                for (int i = 0; i < 6; i++) wr(8'h10, 8'(8'h30 + i));
                rd_chk("tx_ovf_status", 8'h11, 8'h20);
            end
            for (int j = 0; j < 5; j++) begin
                tx_frame(0, w);
                if (j > 0) check("tx_gap", 16'(w), 16'd0);
            end
        join
        wr(8'h12, 8'h80);
        rd_chk("tx_ovf_clr", 8'h11, 8'h06);
        rd_chk("ctrl_bit7_not_stored", 8'h12, 8'h00);

        rxq.push_back(8'h3C);
        send_byte(8'h3C, 1);
        rd_chk("rx_status_avail", 8'h11, 8'h07);
        rx_pop_chk("rx_data");
        rd_chk("rx_status_empty", 8'h11, 8'h06);
        rd_chk("rx_read_empty", 8'h10, 8'h00);

        for (int i = 0; i < 5; i++) begin
            if (i < 4) rxq.push_back(8'(8'h11 * (i + 1)));
            send_byte(8'(8'h11 * (i + 1)), 1);
        end
        rd_chk("rx_ovr_status", 8'h11, 8'h0F);
        for (int i = 0; i < 4; i++) rx_pop_chk("rx_fifo_order");
        rd_chk("rx_after_drain", 8'h11, 8'h0E);
        wr(8'h12, 8'h80);
        rd_chk("rx_ovr_clr", 8'h11, 8'h06);

        rxq.push_back(8'h5A);
        send_byte(8'h5A, 1);
        rxq.push_back(8'h77);
        send_byte(8'h77, 1);
        address = 8'h10; port_rd = 1; ce = 0;
        repeat (2) @(negedge clock);
        ce = 1;
        #1 check("ce_pop_data", 16'(port_in), 16'(rxq.pop_front()));
        @(negedge clock);
        ce = 0;
        @(negedge clock);
        port_rd = 0; ce = 1;
        rx_pop_chk("ce_single_pop");
        rd_chk("ce_empty", 8'h11, 8'h06);
        address = 8'h55;
        #1 check("out_of_range", 16'(port_in), 16'hFF);
        @(negedge clock);

        send_byte(8'h81, 0);
        rd_chk("frame_err_status", 8'h11, 8'h16);
        wr(8'h12, 8'h80);
        rd_chk("frame_err_clr", 8'h11, 8'h06);
        rxd = 0;
        repeat (2) @(negedge clock);
        rxd = 1;
        repeat (40) @(negedge clock);
        rd_chk("glitch_ignored", 8'h11, 8'h06);

        wr(8'h12, 8'h01);
        @(negedge clock);
        check("irq_rx_ie_empty", 16'(irq), 16'd0);
        rxq.push_back(8'h99);
        address = 8'h11;
        seen = 0;
        fork
            send_byte(8'h99, 1);
            begin
                for (int k = 0; k < 200 && !seen; k++) begin
                    @(negedge clock);
                    if (port_in[0]) begin
                        seen = 1;
                        check("irq_lag", 16'(irq), 16'd0);
                        @(negedge clock);
                        check("irq_rx", 16'(irq), 16'd1);
                    end
                end
                check("rx_avail_seen", 16'(seen), 16'd1);
            end
        join
        rx_pop_chk("irq_rx_data");
        @(negedge clock);
        check("irq_clear", 16'(irq), 16'd0);
        wr(8'h12, 8'h02);
        @(negedge clock);
        check("irq_tx_idle", 16'(irq), 16'd1);

        wr(8'h12, 8'h03);
        send_byte(8'h42, 1);
        check("irq_pre_reset", 16'(irq), 16'd1);
        wr(8'h10, 8'hF0);
        repeat (30) @(negedge clock);
        check("txd_mid_frame", 16'(txd), 16'd0);
        reset_n = 0;
        @(negedge clock);
        check("rst_mid_txd", 16'(txd), 16'd1);
        check("rst_mid_irq", 16'(irq), 16'd0);
        address = 8'h11;
        #1 check("rst_mid_status", 16'(port_in), 16'h06);
        address = 8'h12;
        #1 check("rst_mid_ctrl", 16'(port_in), 16'h00);
        @(negedge clock);
        reset_n = 1;
        repeat (20) @(negedge clock);
        check("rst_quiet_txd", 16'(txd), 16'd1);
        rd_chk("rst_quiet_status", 8'h11, 8'h06);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
